// File: rtl/clk_reset_seq.sv
// Clock-manager reset sequencer: power-on reset, lock wait with timeout,
// bounded retries, lock-loss recovery and software re-sequence request.
module clk_reset_seq #(
  parameter int                 NUM_DCM      = 2,
  parameter logic [NUM_DCM-1:0] CHAN_EN      = '1,
  parameter int                 RST_CYCLES   = 8,
  parameter int                 LOCK_TIMEOUT = 1024,
  parameter int                 MAX_RETRIES  = 4,
  parameter int                 SYNC_STAGES  = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               req,
  input  logic [NUM_DCM-1:0]                 locked,
  output logic [NUM_DCM-1:0]                 dcm_rst,
  output logic                               all_locked,
  output logic                               fail,
  output logic                               lost_lock,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retries,
  output logic [2:0]                         state
);

  localparam int CW = $clog2((RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT);
  localparam int RW = $clog2(MAX_RETRIES + 1);

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_RESET     = 3'd1;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd2;
  localparam logic [2:0] ST_LOCKED    = 3'd3;
  localparam logic [2:0] ST_FAIL      = 3'd4;

  logic [SYNC_STAGES-1:0] req_sync;
  logic [NUM_DCM-1:0]     lock_sync [SYNC_STAGES];
  logic                   req_prev;
  logic                   req_edge;
  logic                   rst_q;
  logic                   lock_ok;

  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    state_n;
  logic [RW-1:0] retries_n;
  logic          lost_n;

  // req_edge is registered, giving SYNC_STAGES+2 cycles from req to dcm_rst
  always_ff @(posedge clk) begin
    if (rst) begin
      req_sync <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) lock_sync[i] <= '0;
      req_prev <= 1'b0;
      req_edge <= 1'b0;
    end else begin
      req_sync     <= {req_sync[SYNC_STAGES-2:0], req};
      lock_sync[0] <= locked;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) lock_sync[i] <= lock_sync[i-1];
      req_prev <= req_sync[SYNC_STAGES-1];
      req_edge <= req_sync[SYNC_STAGES-1] & ~req_prev;
    end
  end

  assign lock_ok = &(lock_sync[SYNC_STAGES-1] | ~CHAN_EN);

  // IDLE is only entered when rst is held for a second consecutive cycle
  always_ff @(posedge clk) rst_q <= rst;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    retries_n = retries;
    lost_n    = lost_lock;
    if (req_edge) begin
      state_n   = ST_RESET;
      cnt_n     = '0;
      retries_n = '0;
      lost_n    = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_n = ST_RESET;
          cnt_n   = '0;
        end
        ST_RESET: begin
          if (cnt == RST_LAST) begin
            state_n = ST_WAIT_LOCK;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_ok) begin
            state_n = ST_LOCKED;
            cnt_n   = '0;
          end else if (cnt == TO_LAST) begin
            cnt_n     = '0;
            retries_n = retries + RW'(1);
            state_n   = ((retries + RW'(1)) < RETRY_MAX) ? ST_RESET : ST_FAIL;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        ST_LOCKED: begin
          if (!lock_ok) begin
            state_n   = ST_RESET;
            cnt_n     = '0;
            retries_n = '0;
            lost_n    = 1'b1;
          end
        end
        ST_FAIL: ;
        default: begin
          state_n = ST_RESET;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= rst_q ? ST_IDLE : ST_RESET;
      cnt        <= '0;
      retries    <= '0;
      lost_lock  <= 1'b0;
      fail       <= 1'b0;
      all_locked <= 1'b0;
      dcm_rst    <= '1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      retries    <= retries_n;
      lost_lock  <= lost_n;
      fail       <= (state_n == ST_FAIL);
      all_locked <= (state_n == ST_LOCKED);
      dcm_rst    <= (state_n == ST_IDLE || state_n == ST_RESET || state_n == ST_FAIL)
                    ? '1 : ~CHAN_EN;
    end
  end

endmodule

// File: tb/tb_clk_reset_seq.sv
// Bench for clk_reset_seq: three channel-mask variants driven in parallel and
// compared each cycle against a behavioural model, plus directed latency checks.
module tb_clk_reset_seq;

  localparam int RSTC = 8;
  localparam int TO   = 16;
  localparam int MAXR = 4;
  localparam int SYNC = 3;

  localparam int P_IDLE = 0, P_RESET = 1, P_WAIT = 2, P_LOCKED = 3, P_FAIL = 4;

  localparam logic [2:0][1:0] EN_TAB = {2'b00, 2'b01, 2'b11};

  logic clk = 1'b0;
  logic rst, req;
  logic [1:0] locked;

  logic [2:0][1:0] d_dcm;
  logic [2:0]      d_all, d_fail, d_lost;
  logic [2:0][2:0] d_ret, d_st;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    clk_reset_seq #(
      .NUM_DCM     (2),
      .CHAN_EN     (EN_TAB[g]),
      .RST_CYCLES  (RSTC),
      .LOCK_TIMEOUT(TO),
      .MAX_RETRIES (MAXR),
      .SYNC_STAGES (SYNC)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .locked    (locked),
      .dcm_rst   (d_dcm[g]),
      .all_locked(d_all[g]),
      .fail      (d_fail[g]),
      .lost_lock (d_lost[g]),
      .retries   (d_ret[g]),
      .state     (d_st[g])
    );
  end

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  bit          chk_on = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Behavioural model: synchronisers are plain delay lines, sequencing is
  // expressed as phase + elapsed cycles in that phase.
  int            m_phase [3];
  int            m_cnt   [3];
  int            m_ret   [3];
  bit            m_fail  [3];
  bit            m_lost  [3];
  bit            m_all   [3];
  bit            m_prev  [3];
  bit            m_edge  [3];
  bit            m_rsth  [3];
  bit [1:0]      m_dcm   [3];
  bit [SYNC-1:0]   m_rqd [3];
  bit [2*SYNC-1:0] m_lkd [3];

  task automatic m_step(input int k, input bit r, input bit rq, input bit [1:0] lk);
    bit [1:0] en, lk_s;
    bit rq_s, ok, edge_old, rsth_old;
    en       = EN_TAB[k];
    rq_s     = m_rqd[k][SYNC-1];
    lk_s     = m_lkd[k][2*SYNC-1 -: 2];
    ok       = ((lk_s | ~en) == 2'b11);
    edge_old = m_edge[k];
    rsth_old = m_rsth[k];
    m_rsth[k] = r;
    if (r) begin
      m_phase[k] = rsth_old ? P_IDLE : P_RESET;
      m_cnt[k] = 0; m_ret[k] = 0; m_lost[k] = 0;
      m_rqd[k] = '0; m_lkd[k] = '0; m_prev[k] = 0; m_edge[k] = 0;
    end else begin
      m_edge[k] = rq_s & ~m_prev[k];
      m_prev[k] = rq_s;
      m_rqd[k]  = {m_rqd[k][SYNC-2:0], rq};
      m_lkd[k]  = {m_lkd[k][2*SYNC-3:0], lk};
      if (edge_old) begin
        m_phase[k] = P_RESET; m_cnt[k] = 0; m_ret[k] = 0; m_lost[k] = 0;
      end else begin
        case (m_phase[k])
          P_IDLE: begin m_phase[k] = P_RESET; m_cnt[k] = 0; end
          P_RESET:
            if (m_cnt[k] == RSTC - 1) begin m_phase[k] = P_WAIT; m_cnt[k] = 0; end
            else m_cnt[k]++;
          P_WAIT:
            if (ok) m_phase[k] = P_LOCKED;
            else if (m_cnt[k] == TO - 1) begin
              m_ret[k]++;
              m_cnt[k]   = 0;
              m_phase[k] = (m_ret[k] < MAXR) ? P_RESET : P_FAIL;
            end else m_cnt[k]++;
          P_LOCKED:
            if (!ok) begin
              m_lost[k] = 1; m_ret[k] = 0; m_phase[k] = P_RESET; m_cnt[k] = 0;
            end
          default: ;
        endcase
      end
    end
    m_dcm[k]  = (m_phase[k] == P_IDLE || m_phase[k] == P_RESET || m_phase[k] == P_FAIL)
                ? 2'b11 : ~en;
    m_all[k]  = (m_phase[k] == P_LOCKED);
    m_fail[k] = (m_phase[k] == P_FAIL);
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("k%0d.state", k),      d_st[k],   m_phase[k]);
      check($sformatf("k%0d.dcm_rst", k),    d_dcm[k],  m_dcm[k]);
      check($sformatf("k%0d.all_locked", k), d_all[k],  m_all[k]);
      check($sformatf("k%0d.fail", k),       d_fail[k], m_fail[k]);
      check($sformatf("k%0d.lost_lock", k),  d_lost[k], m_lost[k]);
      check($sformatf("k%0d.retries", k),    d_ret[k],  m_ret[k]);
    end
  endtask

  task automatic tick(input bit r, input bit rq, input bit [1:0] lk);
    rst = r; req = rq; locked = lk;
    for (int k = 0; k < 3; k++) m_step(k, r, rq, lk);
    @(posedge clk);
    @(negedge clk);
    if (chk_on) compare_all();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    bit seen;
    bit r, rq;
    bit [1:0] lk;

    repeat (4) tick(1, 0, 2'b00);
    chk_on = 1;
    check("idle_while_rst", d_st[0], P_IDLE);

    // power-up, lock arrives while waiting
    for (int i = 0; i < 20; i++) tick(0, 0, 2'b00);
    tick(0, 0, 2'b11);
    n = 1;
    while (!d_all[0] && n < 12) begin tick(0, 0, 2'b11); n++; end
    check("lock_latency", n, SYNC + 1);
    check("pwr_retries", d_ret[0], 0);

    // no lock ever: retries until FAIL
    tick(1, 0, 2'b00); tick(1, 0, 2'b00);
    n = 0;
    do begin tick(0, 0, 2'b00); n++; end while (!d_fail[0] && n < 200);
    check("fail_time", n, 1 + MAXR * (RSTC + TO));
    check("fail_state", d_st[0], P_FAIL);
    check("fail_dcm", d_dcm[0], 2'b11);
    check("fail_retries", d_ret[0], MAXR);
    repeat (10) tick(0, 0, 2'b00);

    // recovery from FAIL by a one-cycle req pulse
    tick(0, 1, 2'b00);
    n = 1;
    while (d_fail[0] && n < 12) begin tick(0, 0, 2'b00); n++; end
    check("req_latency", n, SYNC + 2);
    check("recov_retries", d_ret[0], 0);
    check("recov_dcm", d_dcm[0], 2'b11);
    repeat (5) tick(0, 0, 2'b00);
    n = 0;
    while (!d_all[0] && n < 40) begin tick(0, 0, 2'b11); n++; end
    check("recov_locked", d_all[0], 1);

    // lock loss: bit 1 drops for two cycles
    repeat (5) tick(0, 0, 2'b11);
    n = 0; seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick(0, 0, (i < 2) ? 2'b01 : 2'b11);
      n++;
      if (!d_all[0]) seen = 1;
    end
    check("loss_latency", n, SYNC + 1);
    check("loss_sticky", d_lost[0], 1);
    n = 0;
    while (!d_all[0] && n < 60) begin tick(0, 0, 2'b11); n++; end
    check("relock", d_all[0], 1);
    check("relock_lost", d_lost[0], 1);

    // lock arriving exactly on the timeout cycle of the second attempt
    tick(1, 0, 2'b00);
    n = 0;
    while (!(m_phase[0] == P_WAIT && m_ret[0] == 1 && m_cnt[0] == TO - 4) && n < 200) begin
      tick(0, 0, 2'b00); n++;
    end
    repeat (4) tick(0, 0, 2'b11);
    check("lock_at_timeout_state", d_st[0], P_LOCKED);
    check("lock_at_timeout_retries", d_ret[0], 1);

    // req edge mid-RESET restarts the full pulse
    tick(1, 0, 2'b00);
    tick(0, 1, 2'b00);
    n = 0;
    while (d_dcm[0] == 2'b11 && n < 40) begin n++; tick(0, 0, 2'b00); end
    check("req_restart_len", n, SYNC + 1 + RSTC);

    // rst during WAIT_LOCK with a nonzero retry count
    n = 0;
    while (!(m_phase[0] == P_WAIT && m_ret[0] == 1) && n < 100) begin
      tick(0, 0, 2'b00); n++;
    end
    tick(1, 0, 2'b00);
    check("rst_wait_state", d_st[0], P_RESET);
    check("rst_wait_dcm", d_dcm[0], 2'b11);
    check("rst_wait_retries", d_ret[0], 0);

    // randomized traffic
    rq = 0; lk = 2'b00;
    for (int i = 0; i < 2500; i++) begin
      r = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 99) == 0) rq = ~rq;
      for (int b = 0; b < 2; b++) if ($urandom_range(0, 24) == 0) lk[b] = ~lk[b];
      if (lk != 2'b11 && $urandom_range(0, 39) == 0) lk = 2'b11;
      tick(r, rq, lk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
